// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared definitions for the up/down sweep sequencer: controller state encoding and
// counter direction codes used by both the controller and the counter core.
package updown_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/updown_sweep_ctrl_core.sv
// Plain up/down counter datapath: synchronous load has priority over counting,
// counting only happens while en is high, direction chosen by mode.
module updown_sweep_ctrl_core
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d_in,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (ld) begin
      count <= d_in;
    end else if (en) begin
      count <= (mode == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer: loads lo, counts up to hi and back to lo, repeated for a
// programmed number of sweeps (0 = until abort). Owns the counter core's controls.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; bounds validated here, err on lo >= hi
// ST_UP   | counting toward latched hi, dir = 1
// ST_DOWN | counting toward latched lo, sweep bookkeeping at the floor
// ST_DONE | one-cycle done pulse, count parked at lo
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo_val,
  input  logic [WIDTH-1:0]   hi_val,
  input  logic [SWEEP_W-1:0] sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   lo_r, hi_r;
  logic [SWEEP_W-1:0] remaining;
  logic               accept, reject, at_peak, at_floor;
  logic               ld, en, mode;

  // abort in IDLE suppresses both a load and an error report
  assign accept   = (state == ST_IDLE) && start && !abort && (lo_val < hi_val);
  assign reject   = (state == ST_IDLE) && start && !abort && (lo_val >= hi_val);
  assign at_peak  = (count + WIDTH'(1)) == hi_r;
  assign at_floor = (count - WIDTH'(1)) == lo_r;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state != ST_IDLE && abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nxt = ST_UP;
        ST_UP:   if (at_peak) state_nxt = ST_DOWN;
        ST_DOWN: begin
          if (at_floor) begin
            // remaining == 0 means continuous: always turn around
            state_nxt = (remaining == SWEEP_W'(1)) ? ST_DONE : ST_UP;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    dir  = DIR_DN;
    done = 1'b0;
    ld   = accept;
    en   = 1'b0;
    case (state)
      ST_UP: begin
        busy = 1'b1;
        dir  = DIR_UP;
        en   = !abort;
      end
      ST_DOWN: begin
        busy = 1'b1;
        en   = !abort;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
    mode = dir;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      lo_r      <= '0;
      hi_r      <= '0;
      remaining <= '0;
      err       <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        lo_r      <= lo_val;
        hi_r      <= hi_val;
        remaining <= sweeps;
      end else if (state == ST_DOWN && at_floor && !abort && remaining > SWEEP_W'(1)) begin
        remaining <= remaining - SWEEP_W'(1);
      end
    end
  end

  updown_sweep_ctrl_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .clear_n (clear_n),
    .ld      (ld),
    .d_in    (lo_val),
    .mode    (mode),
    .en      (en),
    .count   (count)
  );

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: expected per-cycle outputs are queued when a
// run is launched and compared on each falling edge.
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       start, abort;
  logic [7:0] lo_val, hi_val, sweeps;
  logic [7:0] count;
  logic       dir, busy, done, err;
  logic [11:0] obs;

  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_count  = 0;
  int          peaks;

  always #5 clk = ~clk;

  updown_sweep_ctrl dut (
    .clk     (clk),
    .clear_n (clear_n),
    .start   (start),
    .abort   (abort),
    .lo_val  (lo_val),
    .hi_val  (hi_val),
    .sweeps  (sweeps),
    .count   (count),
    .dir     (dir),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  assign obs = {count, dir, busy, done, err};

  function automatic logic [11:0] pk(input int c, input logic d, input logic b,
                                     input logic dn, input logic e);
    return {c[7:0], d, b, dn, e};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (count,dir,busy,done,err)", tag, got, exp);
  endtask

  // expected samples from the load edge onward; sw == 0 models four continuous sweeps
  task automatic push_run(input int lo, input int hi, input int sw);
    int nsw;
    nsw = (sw == 0) ? 4 : sw;
    exp_q.push_back(pk(lo, 1, 1, 0, 0));
    for (int s = 1; s <= nsw; s++) begin
      for (int v = lo + 1; v < hi; v++) exp_q.push_back(pk(v, 1, 1, 0, 0));
      exp_q.push_back(pk(hi, 0, 1, 0, 0));
      for (int v = hi - 1; v > lo; v--) exp_q.push_back(pk(v, 0, 1, 0, 0));
      if (sw != 0 && s == nsw) exp_q.push_back(pk(lo, 0, 0, 1, 0));
      else                     exp_q.push_back(pk(lo, 1, 1, 0, 0));
    end
    if (sw != 0) exp_q.push_back(pk(lo, 0, 0, 0, 0));
    m_count = lo;
  endtask

  task automatic step_check(input string tag);
    logic [11:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(tag, 32'(obs), 32'(e));
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step_check(tag);
  endtask

  task automatic start_run(input int lo, input int hi, input int sw, input string tag);
    @(negedge clk);
    lo_val = 8'(lo);
    hi_val = 8'(hi);
    sweeps = 8'(sw);
    start  = 1'b1;
    push_run(lo, hi, sw);
    step_check(tag);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    lo_val  = '0;
    hi_val  = '0;
    sweeps  = '0;
    repeat (3) @(negedge clk);
    clear_n = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    step_check("reset");

    start_run(2, 5, 1, "sweep_2_5");
    drain("sweep_2_5");

    peaks = 0;
    start_run(0, 1, 3, "sweep_0_1");
    while (exp_q.size() > 0) begin
      step_check("sweep_0_1");
      if (count == 8'd1) peaks++;
    end
    check_val("peaks_0_1", 32'(peaks), 32'd3);

    @(negedge clk);
    lo_val = 8'd7; hi_val = 8'd7; sweeps = 8'd1; start = 1'b1;
    exp_q.push_back(pk(m_count, 0, 0, 0, 1));
    exp_q.push_back(pk(m_count, 0, 0, 0, 0));
    step_check("err_pulse");
    start = 1'b0;
    step_check("err_clear");

    @(negedge clk);
    lo_val = 8'd1; hi_val = 8'd3; start = 1'b1; abort = 1'b1;
    exp_q.push_back(pk(m_count, 0, 0, 0, 0));
    exp_q.push_back(pk(m_count, 0, 0, 0, 0));
    step_check("abort_start");
    start = 1'b0; abort = 1'b0;
    step_check("abort_start_idle");

    start_run(10, 12, 0, "cont");
    repeat (8) step_check("cont");
    abort = 1'b1;
    exp_q.delete();
    repeat (3) exp_q.push_back(pk(10, 0, 0, 0, 0));
    m_count = 10;
    step_check("abort_hold");
    abort = 1'b0;
    drain("abort_idle");

    start_run(1, 4, 2, "busy_start");
    lo_val = 8'd0; hi_val = 8'd9; sweeps = 8'd5; start = 1'b1;
    repeat (4) step_check("busy_start");
    start = 1'b0;
    drain("busy_start");

    start_run(0, 255, 1, "full_range");
    drain("full_range");

    start_run(3, 6, 2, "pre_rst");
    repeat (4) step_check("pre_rst");
    #2 clear_n = 1'b0;
    #1 check_val("async_rst", 32'(obs), 32'(pk(0, 0, 0, 0, 0)));
    exp_q.delete();
    m_count = 0;
    @(negedge clk);
    clear_n = 1'b1;
    start_run(2, 5, 1, "restart");
    drain("restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
